// File: rtl/sram_rw_requester.sv
// Purpose : initiator for a 128x64 single-port RW0 SRAM macro; zero-fills the array after reset,
//           then serves read/write requests and returns read data in order.
// Latency : writes presented in the accept cycle; read data appears on resp_* 2 cycles after accept.
// Backpressure: req_ready drops once two reads are in flight/buffered and the consumer is not popping.
//
// Ports:
//   clock, reset                       - single clock (also the macro clock), async active-high reset
//   req_valid/req_ready/req_write/req_addr/req_wdata - request channel
//   resp_valid/resp_ready/resp_rdata   - in-order read response channel (2-entry buffer)
//   init_done                          - zero-fill finished, stays high until reset
//   sram_addr/sram_en/sram_wmode/sram_wdata/sram_rdata - macro RW0 port
module sram_rw_requester #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              init_done,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rd_pend_q, rd_pend_d;

    // Last accepted request, kept on the macro pins while idle.
    logic [ADDR_W-1:0] hold_addr_q;
    logic              hold_wmode_q;
    logic [DATA_W-1:0] hold_wdata_q;

    // 2-entry response buffer.
    logic [DATA_W-1:0] fifo_q [2];
    logic              rd_ptr_q;
    logic              wr_ptr_q;
    logic [1:0]        occ_q;

    logic              accept;
    logic              push;
    logic              pop;

    assign init_done  = (state_q == ST_RUN);
    assign resp_valid = (occ_q != 2'd0);
    assign resp_rdata = fifo_q[rd_ptr_q];
    assign pop        = resp_valid && resp_ready;
    // The macro's read data is only meaningful the cycle after a read was issued.
    assign push       = rd_pend_q;

    // Credits count both buffered and in-flight reads; a same-cycle pop frees one.
    // Writes are gated too so the request stream stays strictly ordered.
    assign req_ready = init_done &&
                       ((({1'b0, occ_q} + {2'b00, rd_pend_q}) < 3'd2) || pop);
    assign accept    = req_valid && req_ready;
    assign rd_pend_d = accept && !req_write;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    // Macro drive: fill writes during INIT, request pass-through on accept.
    // Reset is folded in so the macro sees no enable while reset is held.
    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = hold_wmode_q;
        sram_addr  = hold_addr_q;
        sram_wdata = hold_wdata_q;
        if (!reset) begin
            if (state_q == ST_INIT) begin
                sram_en    = 1'b1;
                sram_wmode = 1'b1;
                sram_addr  = cnt_q;
                sram_wdata = '0;
            end else if (accept) begin
                sram_en    = 1'b1;
                sram_wmode = req_write;
                sram_addr  = req_addr;
                sram_wdata = req_wdata;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            rd_pend_q    <= 1'b0;
            hold_addr_q  <= '0;
            hold_wmode_q <= 1'b0;
            hold_wdata_q <= '0;
            fifo_q[0]    <= '0;
            fifo_q[1]    <= '0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            occ_q        <= 2'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= rd_pend_d;
            if (accept) begin
                hold_addr_q  <= req_addr;
                hold_wmode_q <= req_write;
                hold_wdata_q <= req_wdata;
            end
            if (push) begin
                fifo_q[wr_ptr_q] <= sram_rdata;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_rw_requester.sv
// Purpose : directed self-checking bench for sram_rw_requester with a behavioural RW0 macro.
// Latency : macro returns read data one cycle after a read enable, random junk otherwise.
// Backpressure: resp_ready is driven per scenario (held low, high, or random).
module tb_sram_rw_requester;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 64;

    logic              clock = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              init_done;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_en;
    logic              sram_wmode;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    int checks = 0;
    int passes = 0;

    always #5 clock = ~clock;

    sram_rw_requester #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .init_done  (init_done),
        .sram_addr  (sram_addr),
        .sram_en    (sram_en),
        .sram_wmode (sram_wmode),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // Behavioural macro: array starts with junk so the zero-fill is observable.
    logic [DATA_W-1:0] mem [DEPTH];
    bit                mem_ready = 1'b0;
    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= {32'hDEADBEEF, 32'(i)};
            mem_ready  <= 1'b1;
            sram_rdata <= '0;
        end else begin
            if (sram_en && sram_wmode) mem[sram_addr] <= sram_wdata;
            if (sram_en && !sram_wmode) sram_rdata <= mem[sram_addr];
            else sram_rdata <= {$urandom, $urandom};
        end
    end

    // Response/accept monitor sampled on the falling edge.
    logic [DATA_W-1:0] got_q [$];
    int                got_cyc [$];
    int                cyc_cnt = 0;
    int                rd_acc  = 0;
    int                pop_cnt = 0;
    int                max_out = 0;
    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;
    always @(negedge clock) begin
        if (!reset) begin
            if (resp_valid && resp_ready) begin
                got_q.push_back(resp_rdata);
                got_cyc.push_back(cyc_cnt);
                pop_cnt++;
            end
            if (req_valid && req_ready && !req_write) rd_acc++;
            if (rd_acc - pop_cnt > max_out) max_out = rd_acc - pop_cnt;
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic put(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
    endtask

    function automatic logic [DATA_W-1:0] pat(input int a);
        return {16'hA5A5, 16'(a), 16'h5A5A, 16'(~a)};
    endfunction

    function automatic logic [DATA_W-1:0] got_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 'x;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        idle();
        resp_ready = 1'b0;
        repeat (3) cyc();
        #1;
        checks++; if ({req_ready, resp_valid, init_done} !== 3'b000) $display("FAIL rst_ctrl: got %b expected 000", {req_ready, resp_valid, init_done}); else passes++;
        checks++; if ({sram_en, sram_wmode} !== 2'b00) $display("FAIL rst_en: got %b expected 00", {sram_en, sram_wmode}); else passes++;
        checks++; if (sram_addr !== '0 || sram_wdata !== '0) $display("FAIL rst_addr_data: got %h/%h expected 0/0", sram_addr, sram_wdata); else passes++;
        checks++; if (resp_rdata !== '0) $display("FAIL rst_rdata: got %h expected 0", resp_rdata); else passes++;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_fill();
        int bad = 0;
        for (int c = 0; c < DEPTH; c++) begin
            #1;
            if (!(sram_en === 1'b1 && sram_wmode === 1'b1 && sram_addr === ADDR_W'(c) &&
                  sram_wdata === '0 && req_ready === 1'b0 && init_done === 1'b0)) bad++;
            cyc();
        end
        #1;
        checks++; if (bad !== 0) $display("FAIL fill_cycles: got %0d bad cycles expected 0", bad); else passes++;
        checks++; if ({init_done, req_ready} !== 2'b11) $display("FAIL fill_done: got %b expected 11", {init_done, req_ready}); else passes++;
        put(1'b0, 7'h55, '0);
        resp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1 || sram_en !== 1'b1 || sram_addr !== 7'h55) $display("FAIL first_accept: got rdy=%b en=%b addr=%h expected 1 1 55", req_ready, sram_en, sram_addr); else passes++;
        cyc();
        idle();
        #1;
        checks++; if (resp_valid !== 1'b0) $display("FAIL first_lat1: got %b expected 0", resp_valid); else passes++;
        cyc();
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== '0) $display("FAIL read_55: got v=%b d=%h expected 1 0", resp_valid, resp_rdata); else passes++;
    endtask

    task automatic test_write_read();
        logic [DATA_W-1:0] x = 64'h0123456789ABCDEF;
        cyc();
        put(1'b1, 7'd5, x);
        resp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1 || sram_en !== 1'b1 || sram_wmode !== 1'b1 || sram_wdata !== x) $display("FAIL wr_drive: got rdy=%b en=%b wm=%b d=%h expected 1 1 1 %h", req_ready, sram_en, sram_wmode, sram_wdata, x); else passes++;
        cyc();
        put(1'b0, 7'd5, '0);
        #1;
        checks++; if (sram_en !== 1'b1 || sram_wmode !== 1'b0 || sram_addr !== 7'd5) $display("FAIL rd_drive: got en=%b wm=%b addr=%h expected 1 0 05", sram_en, sram_wmode, sram_addr); else passes++;
        cyc();
        idle();
        #1;
        checks++; if (resp_valid !== 1'b0) $display("FAIL rd_lat1: got %b expected 0", resp_valid); else passes++;
        cyc();
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== x) $display("FAIL rd_data5: got v=%b d=%h expected 1 %h", resp_valid, resp_rdata, x); else passes++;
        cyc();
        #1;
        checks++; if (resp_valid !== 1'b0) $display("FAIL rd_drain: got %b expected 0", resp_valid); else passes++;
    endtask

    task automatic test_hazard();
        int base = got_q.size();
        resp_ready = 1'b1;
        cyc(); put(1'b1, 7'd3, 64'hAA);
        cyc(); put(1'b0, 7'd3, '0);
        cyc(); put(1'b1, 7'd3, 64'hBB);
        cyc(); put(1'b0, 7'd3, '0);
        cyc(); idle();
        repeat (4) cyc();
        checks++; if (got_q.size() - base !== 2) $display("FAIL hazard_count: got %0d expected 2", got_q.size() - base); else passes++;
        checks++; if (got_at(base) !== 64'hAA) $display("FAIL hazard_first: got %h expected aa", got_at(base)); else passes++;
        checks++; if (got_at(base + 1) !== 64'hBB) $display("FAIL hazard_second: got %h expected bb", got_at(base + 1)); else passes++;
    endtask

    task automatic test_backpressure();
        int base;
        int idx = 1;
        resp_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            put(1'b1, ADDR_W'(i), 64'h1111_1111_1111_1111 * 64'(i));
        end
        cyc();
        idle();
        resp_ready = 1'b0;
        base = got_q.size();
        for (int k = 0; k < 6; k++) begin
            cyc();
            put(1'b0, ADDR_W'(idx), '0);
            #1;
            if (req_ready) idx++;
        end
        checks++; if (idx - 1 !== 2) $display("FAIL bp_accepted: got %0d expected 2", idx - 1); else passes++;
        checks++; if (req_ready !== 1'b0) $display("FAIL bp_stall: got %b expected 0", req_ready); else passes++;
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 64'h1111_1111_1111_1111) $display("FAIL bp_head: got v=%b d=%h expected 1 1111111111111111", resp_valid, resp_rdata); else passes++;
        idle();
        resp_ready = 1'b1;
        for (int k = 0; k < 30 && idx <= 4; k++) begin
            cyc();
            put(1'b0, ADDR_W'(idx), '0);
            #1;
            if (req_ready) idx++;
        end
        cyc();
        idle();
        repeat (5) cyc();
        checks++; if (got_q.size() - base !== 4) $display("FAIL bp_count: got %0d expected 4", got_q.size() - base); else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_at(base + i) !== 64'h1111_1111_1111_1111 * 64'(i + 1)) $display("FAIL bp_order%0d: got %h expected %h", i, got_at(base + i), 64'h1111_1111_1111_1111 * 64'(i + 1));
            else passes++;
        end
    endtask

    task automatic test_stream();
        int base;
        int s = 0;
        int bad_rdy = 0;
        int bad_dat = 0;
        int bad_cyc = 0;
        resp_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            cyc();
            put(1'b1, ADDR_W'(i), pat(i));
            #1;
            if (req_ready !== 1'b1) bad_rdy++;
        end
        base = got_q.size();
        for (int i = 0; i < 64; i++) begin
            cyc();
            put(1'b0, ADDR_W'(i), '0);
            #1;
            if (req_ready !== 1'b1) bad_rdy++;
            if (i == 0) s = cyc_cnt;
        end
        cyc();
        idle();
        repeat (4) cyc();
        checks++; if (bad_rdy !== 0) $display("FAIL stream_ready: got %0d stalls expected 0", bad_rdy); else passes++;
        checks++; if (got_q.size() - base !== 64) $display("FAIL stream_count: got %0d expected 64", got_q.size() - base); else passes++;
        for (int i = 0; i < 64; i++) begin
            if (got_at(base + i) !== pat(i)) bad_dat++;
            if (base + i >= got_cyc.size() || got_cyc[base + i] !== s + 2 + i) bad_cyc++;
        end
        checks++; if (bad_dat !== 0) $display("FAIL stream_data: got %0d wrong expected 0", bad_dat); else passes++;
        checks++; if (bad_cyc !== 0) $display("FAIL stream_timing: got %0d late expected 0", bad_cyc); else passes++;
    endtask

    task automatic test_random();
        int base = got_q.size();
        int idx = 0;
        int bad = 0;
        int addrs [40];
        for (int i = 0; i < 40; i++) addrs[i] = int'($urandom_range(0, 63));
        for (int k = 0; k < 600 && idx < 40; k++) begin
            cyc();
            resp_ready = 1'($urandom_range(0, 1));
            put(1'b0, ADDR_W'(addrs[idx]), '0);
            #1;
            if (req_ready) idx++;
        end
        cyc();
        idle();
        resp_ready = 1'b1;
        repeat (6) cyc();
        checks++; if (idx !== 40) $display("FAIL rand_issue: got %0d expected 40", idx); else passes++;
        checks++; if (got_q.size() - base !== 40) $display("FAIL rand_count: got %0d expected 40", got_q.size() - base); else passes++;
        for (int i = 0; i < 40; i++) if (got_at(base + i) !== pat(addrs[i])) bad++;
        checks++; if (bad !== 0) $display("FAIL rand_order: got %0d wrong expected 0", bad); else passes++;
        checks++; if (max_out > 2) $display("FAIL outstanding_max: got %0d expected <=2", max_out); else passes++;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int bad = 0;
        resp_ready = 1'b0;
        cyc(); put(1'b0, 7'd7, '0);
        cyc(); put(1'b0, 7'd8, '0);
        cyc(); idle();
        repeat (2) cyc();
        #1;
        checks++; if (resp_valid !== 1'b1) $display("FAIL buf_full: got %b expected 1", resp_valid); else passes++;
        reset = 1'b1;
        #1;
        checks++; if ({resp_valid, req_ready, init_done, sram_en} !== 4'b0000) $display("FAIL rst_flush: got %b expected 0000", {resp_valid, req_ready, init_done, sram_en}); else passes++;
        cyc();
        reset = 1'b0;
        repeat (60) cyc();
        #1;
        checks++; if (sram_addr !== 7'd60 || sram_en !== 1'b1) $display("FAIL fill60: got addr=%0d en=%b expected 60 1", sram_addr, sram_en); else passes++;
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        checks++; if (sram_addr !== 7'd0 || sram_en !== 1'b1 || sram_wmode !== 1'b1) $display("FAIL refill_start: got addr=%0d en=%b wm=%b expected 0 1 1", sram_addr, sram_en, sram_wmode); else passes++;
        for (int k = 0; k < 200; k++) begin
            cyc();
            n++;
            #1;
            if (resp_valid !== 1'b0) bad++;
            if (init_done) break;
        end
        checks++; if (n !== 128) $display("FAIL refill_len: got %0d expected 128", n); else passes++;
        checks++; if (bad !== 0) $display("FAIL refill_resp: got %0d stray responses expected 0", bad); else passes++;
        resp_ready = 1'b1;
        put(1'b0, 7'd7, '0);
        #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL refill_accept: got %b expected 1", req_ready); else passes++;
        cyc();
        idle();
        cyc();
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== '0) $display("FAIL refill_zero: got v=%b d=%h expected 1 0", resp_valid, resp_rdata); else passes++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_read();
        test_hazard();
        test_backpressure();
        test_stream();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
